// File: rtl/wdt_reset_req_if.sv
// Watchdog reset requester bus: control inputs from the supervising logic and the
// request/status outputs returned by the watchdog.
interface wdt_reset_req_if #(
   parameter int TIMEOUT_WIDTH = 20
);
   logic                     enable;
   logic                     kick;
   logic [TIMEOUT_WIDTH-1:0] timeout_load;
   logic                     reset_req_n;
   logic                     warn;
   logic                     busy;
   logic [7:0]               expire_cnt;

   modport master (
      output enable, kick, timeout_load,
      input  reset_req_n, warn, busy, expire_cnt
   );

   modport slave (
      input  enable, kick, timeout_load,
      output reset_req_n, warn, busy, expire_cnt
   );
endinterface

// File: rtl/wdt_reset_req.sv
// Watchdog reset requester: issues a fixed-length active-low reset request when kicks stop.
// Optional early-warning flag is built only when WDT_WARN_EN is defined.
module wdt_reset_req #(
   parameter int TIMEOUT_WIDTH = 20,
   parameter int PULSE_LEN     = 16,
   parameter int HOLDOFF_LEN   = 256,
   parameter int WARN_MARGIN   = 1024
) (
   input logic             tx_clk,
   input logic             reset_n_in,
   wdt_reset_req_if.slave  bus
);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ARMED    = 2'd1,
      PULSE    = 2'd2,
      HOLDOFF  = 2'd3
   } state_t;

   localparam int PULSE_W = $clog2(PULSE_LEN);
   localparam int HOLD_W  = $clog2(HOLDOFF_LEN);
   localparam int PH_W    = (PULSE_W > HOLD_W) ? PULSE_W : HOLD_W;
   localparam int CNT_W   = (TIMEOUT_WIDTH > PH_W) ? TIMEOUT_WIDTH : PH_W;

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [CNT_W-1:0] eff_load;
   logic [7:0]       expire_q, expire_next;
   logic             req_n_q, busy_q;

   // A zero timeout would never let the counter leave zero cleanly, so it behaves as 1.
   assign eff_load = (bus.timeout_load == '0) ? CNT_ONE : CNT_W'(bus.timeout_load);

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      expire_next = expire_q;
      case (state)
         DISABLED: begin
            if (bus.enable) begin
               state_next = ARMED;
               cnt_next   = eff_load;
            end
         end
         ARMED: begin
            if (!bus.enable) begin
               state_next = DISABLED;
               cnt_next   = '0;
            end else if (bus.kick) begin
               cnt_next = eff_load;
            end else if (cnt != '0) begin
               cnt_next = cnt - CNT_ONE;
            end else begin
               state_next = PULSE;
               cnt_next   = PULSE_LAST;
               if (expire_q != 8'hFF) begin
                  expire_next = expire_q + 8'd1;
               end
            end
         end
         // The shared counter runs down LEN-1..0, so each timed state lasts exactly LEN cycles.
         PULSE: begin
            if (cnt == '0) begin
               state_next = HOLDOFF;
               cnt_next   = HOLD_LAST;
            end else begin
               cnt_next = cnt - CNT_ONE;
            end
         end
         HOLDOFF: begin
            if (cnt != '0) begin
               cnt_next = cnt - CNT_ONE;
            end else if (bus.enable) begin
               state_next = ARMED;
               cnt_next   = eff_load;
            end else begin
               state_next = DISABLED;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = DISABLED;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge tx_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state    <= DISABLED;
         cnt      <= '0;
         expire_q <= 8'd0;
         req_n_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         expire_q <= expire_next;
         req_n_q  <= (state_next != PULSE);
         busy_q   <= (state_next == PULSE) || (state_next == HOLDOFF);
      end
   end

   assign bus.reset_req_n = req_n_q;
   assign bus.busy        = busy_q;
   assign bus.expire_cnt  = expire_q;

`ifdef WDT_WARN_EN
   localparam logic [CNT_W-1:0] WARN_TH = CNT_W'(WARN_MARGIN);

   logic warn_q, warn_next;

   // Warning follows the next counter value; a kick reload always clears it.
   always_comb begin
      warn_next = (state_next == ARMED) && (cnt_next <= WARN_TH) &&
                  !((state == ARMED) && bus.kick);
   end

   always_ff @(posedge tx_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_next;
      end
   end

   assign bus.warn = warn_q;
`else
   assign bus.warn = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_reset_req.sv
// Directed self-checking bench for wdt_reset_req with hand-computed cycle expectations.
// Warn expectations follow WDT_WARN_EN (WARN_MARGIN=4 here).
module tb_wdt_reset_req;

   localparam int TW = 20;
   localparam int PL = 16;
   localparam int HL = 256;
   localparam int WM = 4;

`ifdef WDT_WARN_EN
   localparam logic WARN_EXP = 1'b1;
`else
   localparam logic WARN_EXP = 1'b0;
`endif

   logic tx_clk = 1'b0;
   logic reset_n_in;

   wdt_reset_req_if #(.TIMEOUT_WIDTH(TW)) bus ();

   wdt_reset_req #(
      .TIMEOUT_WIDTH (TW),
      .PULSE_LEN     (PL),
      .HOLDOFF_LEN   (HL),
      .WARN_MARGIN   (WM)
   ) dut (
      .tx_clk     (tx_clk),
      .reset_n_in (reset_n_in),
      .bus        (bus)
   );

   always #5 tx_clk = ~tx_clk;

   int total = 0;
   int bad   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic kk, input logic [TW-1:0] load);
      bus.enable       = en;
      bus.kick         = kk;
      bus.timeout_load = load;
   endtask

   task automatic step();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // Called right after the edge that entered PULSE; returns low and busy cycle counts.
   task automatic measurePulse(output int low_cnt, output int busy_cnt);
      low_cnt  = 1;
      busy_cnt = 1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (!bus.reset_req_n) low_cnt++;
         if (bus.busy) busy_cnt++;
         else break;
      end
   endtask

   initial begin
      #1_500_000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int   low_cnt, busy_cnt, low_seen, exp_count, cyc;
      logic prev_req;

      // Reset values
      applyStimulus(1'b0, 1'b0, 20'd10);
      reset_n_in = 1'b0;
      #23;
      checkOutput("rst_req_n", bus.reset_req_n, 1);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_warn", bus.warn, 0);
      checkOutput("rst_expire", bus.expire_cnt, 0);
      reset_n_in = 1'b1;
      step();

      // Arm with T=10, no kicks
      applyStimulus(1'b1, 1'b0, 20'd10);
      step();
      steps(5);
      checkOutput("warn_cnt5", bus.warn, 0);
      step();
      checkOutput("warn_cnt4", bus.warn, WARN_EXP);
      steps(4);
      checkOutput("no_early_expiry", bus.reset_req_n, 1);
      step();
      checkOutput("expiry_edge", bus.reset_req_n, 0);
      checkOutput("expiry_busy", bus.busy, 1);
      checkOutput("expiry_cnt1", bus.expire_cnt, 1);
      checkOutput("pulse_warn", bus.warn, 0);
      measurePulse(low_cnt, busy_cnt);
      checkOutput("pulse_len", low_cnt, 16);
      checkOutput("busy_len", busy_cnt, 272);

      // Block re-armed on the holdoff end edge
      steps(10);
      checkOutput("rearm_hold", bus.reset_req_n, 1);
      step();
      checkOutput("rearm_expiry", bus.reset_req_n, 0);
      checkOutput("rearm_cnt2", bus.expire_cnt, 2);

      // Disabling during PULSE must not truncate the pulse
      applyStimulus(1'b0, 1'b0, 20'd10);
      measurePulse(low_cnt, busy_cnt);
      checkOutput("dis_pulse_len", low_cnt, 16);
      checkOutput("dis_busy_len", busy_cnt, 272);
      steps(50);
      checkOutput("dis_idle_req", bus.reset_req_n, 1);
      checkOutput("dis_idle_busy", bus.busy, 0);
      checkOutput("dis_idle_cnt", bus.expire_cnt, 2);

      // Kick every 8 cycles for 1000 cycles
      applyStimulus(1'b1, 1'b0, 20'd10);
      step();
      low_seen = 0;
      for (int c = 1; c <= 1000; c++) begin
         applyStimulus(1'b1, (c % 8) == 0, 20'd10);
         step();
         if (!bus.reset_req_n) low_seen++;
         if (c == 999) checkOutput("warn_before_kick", bus.warn, WARN_EXP);
         if (c == 1000) checkOutput("warn_kick_clear", bus.warn, 0);
      end
      checkOutput("kick_no_low", low_seen, 0);
      checkOutput("kick_cnt", bus.expire_cnt, 2);
      applyStimulus(1'b1, 1'b0, 20'd10);
      steps(10);
      checkOutput("after_kick_hold", bus.reset_req_n, 1);
      step();
      checkOutput("after_kick_expiry", bus.reset_req_n, 0);
      checkOutput("after_kick_cnt3", bus.expire_cnt, 3);
      measurePulse(low_cnt, busy_cnt);
      checkOutput("pulse3_len", low_cnt, 16);
      checkOutput("rearm_wait", bus.busy, 0);

      // Kick on the cycle the counter is zero
      steps(10);
      applyStimulus(1'b1, 1'b1, 20'd10);
      step();
      checkOutput("kick_at_zero", bus.reset_req_n, 1);
      applyStimulus(1'b1, 1'b0, 20'd10);
      steps(10);
      checkOutput("kick_reload_hold", bus.reset_req_n, 1);
      step();
      checkOutput("kick_reload_expiry", bus.reset_req_n, 0);
      checkOutput("kick_reload_cnt4", bus.expire_cnt, 4);
      measurePulse(low_cnt, busy_cnt);
      checkOutput("busy4_len", busy_cnt, 272);

      // enable=0 while ARMED with counter=3
      steps(7);
      applyStimulus(1'b0, 1'b0, 20'd10);
      step();
      low_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (!bus.reset_req_n) low_seen++;
      end
      checkOutput("disarm_no_pulse", low_seen, 0);
      checkOutput("disarm_busy", bus.busy, 0);
      checkOutput("disarm_cnt", bus.expire_cnt, 4);

      // Asynchronous reset in pulse cycle 5
      applyStimulus(1'b1, 1'b0, 20'd10);
      step();
      steps(11);
      checkOutput("pre_rst_expiry", bus.expire_cnt, 5);
      steps(4);
      checkOutput("pulse_cycle5", bus.reset_req_n, 0);
      #2;
      reset_n_in = 1'b0;
      #1;
      checkOutput("async_req_n", bus.reset_req_n, 1);
      checkOutput("async_busy", bus.busy, 0);
      checkOutput("async_expire", bus.expire_cnt, 0);
      checkOutput("async_warn", bus.warn, 0);
      applyStimulus(1'b0, 1'b0, 20'd10);
      #3;
      reset_n_in = 1'b1;
      steps(20);
      checkOutput("post_rst_req_n", bus.reset_req_n, 1);
      checkOutput("post_rst_busy", bus.busy, 0);
      checkOutput("post_rst_cnt", bus.expire_cnt, 0);

      // timeout_load=0 behaves as 1, then saturate the expiry counter
      applyStimulus(1'b1, 1'b0, 20'd0);
      step();
      step();
      checkOutput("load0_edge1", bus.reset_req_n, 1);
      step();
      checkOutput("load0_expiry", bus.reset_req_n, 0);
      checkOutput("load0_cnt1", bus.expire_cnt, 1);
      prev_req  = bus.reset_req_n;
      exp_count = 1;
      cyc       = 0;
      while (exp_count < 257 && cyc < 80000) begin
         step();
         cyc++;
         if (prev_req && !bus.reset_req_n) begin
            exp_count++;
            if (exp_count == 255) checkOutput("sat_255", bus.expire_cnt, 255);
         end
         prev_req = bus.reset_req_n;
      end
      checkOutput("sat_reached", exp_count, 257);
      checkOutput("sat_hold", bus.expire_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
